qpsk_bit_splitter: RTL and testbench

QPSK_BIT_SPLITTER -- requirements
Module: qpsk_bit_splitter

---
 rtl/qpsk_bit_splitter.sv | 140 ++++++++++++++
 tb/tb_qpsk_bit_splitter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_bit_splitter.sv
// ---------------------------------------------------------------------------
// qpsk_bit_splitter
//
// Purpose:
//   Collects a serial bit stream into dibits and presents each dibit to a
//   QPSK modulator as an {O,E} pair that is held for one full symbol
//   (SYMBOL_LEN clocks). The first bit of a dibit becomes O (odd, MSB) and
//   the second becomes E (even, LSB). When a symbol boundary passes with no
//   complete dibit buffered, the previous pair is held and Underrun pulses.
//
// Parameters:
//   SYMBOL_LEN  clocks per symbol, legal range 2..127
//
// Ports:
//   Clk         clock, all logic on the rising edge
//   Rst         synchronous active-high reset
//   Din         serial data bit
//   Din_valid   Din is valid this cycle
//   Din_ready   block accepts Din this cycle (combinational from state)
//   O           odd bit (dibit MSB) to the modulator, held for the symbol
//   E           even bit (dibit LSB) to the modulator, held for the symbol
//   Sym_strobe  one-cycle pulse in the first cycle a new O/E pair is driven
//   Underrun    one-cycle pulse when a boundary passes with no full dibit
//
// Configuration:
//   QPSK_DIFF_ENC_EN  when defined, {O,E} is differentially encoded as
//                     phase p_new = (p_prev + dibit) mod 4, where p_prev is
//                     the currently driven {O,E}. Otherwise {O,E} is the
//                     dibit itself and no phase state exists.
// ---------------------------------------------------------------------------
module qpsk_bit_splitter #(
    parameter int SYMBOL_LEN = 100
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Din,
    input  logic Din_valid,
    output logic Din_ready,
    output logic O,
    output logic E,
    output logic Sym_strobe,
    output logic Underrun
);

    localparam int              CW   = 7;
    localparam logic [CW-1:0]   LAST = CW'(SYMBOL_LEN - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      fill_q, fill_d;
    logic [1:0]      buf_q,  buf_d;
    logic            o_q, e_q;
    logic            stb_q, und_q;

    logic            full;
    logic            accept;
    logic            boundary;
    logic            load;
    logic [1:0]      sym_d;

    assign full      = (fill_q == 2'd2);
    assign Din_ready = ~Rst & ~full;
    assign accept    = Din_valid & Din_ready;
    assign boundary  = (state_q == RUN) && (cnt_q == LAST);

    // A load happens on the first edge a full dibit is seen while idle, or on
    // a symbol boundary. It uses the pre-edge fill, so a bit arriving on the
    // same edge as a boundary is only buffered.
    assign load      = full & ((state_q == IDLE) | boundary);

`ifdef QPSK_DIFF_ENC_EN
    // The driven {O,E} doubles as the previous phase; 2-bit add wraps mod 4.
    assign sym_d = {o_q, e_q} + buf_q;
`else
    assign sym_d = buf_q;
`endif

    // Buffer: shift left so the first bit of the dibit ends up in buf_q[1].
    // Ready is low while full, so load and accept never coincide.
    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        if (load) begin
            fill_d = 2'd0;
        end else if (accept) begin
            buf_d  = {buf_q[0], Din};
            fill_d = fill_q + 2'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= 2'd0;
            buf_q   <= 2'd0;
            o_q     <= 1'b0;
            e_q     <= 1'b0;
            stb_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            fill_q <= fill_d;
            buf_q  <= buf_d;
            stb_q  <= load;
            und_q  <= boundary & ~full;
            if (load) begin
                {o_q, e_q} <= sym_d;
            end
            case (state_q)
                IDLE: begin
                    // Counter stays parked at 0 until the first dibit loads.
                    cnt_q <= '0;
                    if (full) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Once running, the symbol clock never stops; underruns
                    // just hold the previous pair.
                    cnt_q <= boundary ? '0 : cnt_q + CW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign O          = o_q;
    assign E          = e_q;
    assign Sym_strobe = stb_q;
    assign Underrun   = und_q;

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// ---------------------------------------------------------------------------
// tb_qpsk_bit_splitter
//
// Directed bench for qpsk_bit_splitter with SYMBOL_LEN = 100. A per-cycle
// vector table covers reset and the first dibit; hand-written sequences
// cover continuous streams, underrun, mid-symbol reset and a dibit that
// completes exactly on a boundary edge. Expected {O,E} comes from a small
// phase model that follows QPSK_DIFF_ENC_EN the same way the block does.
// ---------------------------------------------------------------------------
module tb_qpsk_bit_splitter;

    localparam int L = 100;

    logic Clk = 1'b0;
    logic Rst, Din, Din_valid;
    logic Din_ready, O, E, Sym_strobe, Underrun;

    int checks   = 0;
    int failures = 0;
    logic [1:0] ph_m;

    qpsk_bit_splitter #(.SYMBOL_LEN(L)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Din_ready  (Din_ready),
        .O          (O),
        .E          (E),
        .Sym_strobe (Sym_strobe),
        .Underrun   (Underrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic rst, vld, din;
        logic rdy, o, e, stb, und;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input logic [1:0] p, input logic [1:0] d);
`ifdef QPSK_DIFF_ENC_EN
        return p + d;
`else
        return d;
`endif
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Din_valid = 1'b0; Din = 1'b0;
        cyc();
        Rst = 1'b0;
        ph_m = 2'd0;
    endtask

    // Full-rate stream: bits[0] is sent first. Checks each loaded pair,
    // exact symbol spacing, hold between strobes and Din_ready behaviour.
    task automatic run_stream(input string nm, input logic [7:0] bits, input int nb);
        int idx = 0, nstb = 0, since = 1000;
        logic rdy;
        logic [1:0] prev, expd, dib;
        do_reset();
        prev = 2'b00;
        for (int c = 0; c < nb * 50 + 150; c++) begin
            Din_valid = (idx < nb);
            Din       = (idx < nb) ? bits[idx] : 1'b0;
            #1 rdy = Din_ready;
            if (since == 0)              chk({nm, " ready after strobe"}, rdy, 1);
            if (since == 50 && idx < nb) chk({nm, " ready low when full"}, rdy, 0);
            cyc();
            if (rdy && Din_valid) idx++;
            since++;
            if (Sym_strobe) begin
                dib  = {bits[2*nstb], bits[2*nstb+1]};
                expd = enc(ph_m, dib);
                ph_m = expd;
                chk({nm, " pair"}, {O, E}, expd);
                if (nstb > 0) chk({nm, " symbol length"}, since, L);
                since = 0;
                nstb++;
                prev = {O, E};
            end else begin
                chk({nm, " hold"}, {O, E}, prev);
            end
        end
        chk({nm, " strobe count"}, nstb, nb / 2);
    endtask

    // One dibit then silence: periodic underruns with O/E held.
    task automatic run_underrun();
        int nstb = 0, nund = 0, since = 0;
        logic [1:0] expd;
        do_reset();
        for (int c = 0; c < 350; c++) begin
            Din_valid = (c < 2);
            Din       = (c == 0);
            cyc();
            since++;
            if (Sym_strobe) begin
                expd = enc(ph_m, 2'b10);
                ph_m = expd;
                chk("und first pair", {O, E}, expd);
                since = 0;
                nstb++;
            end
            if (Underrun) begin
                chk("und spacing", since, L);
                chk("und hold", {O, E}, ph_m);
                chk("und no strobe", Sym_strobe, 0);
                since = 0;
                nund++;
            end
        end
        chk("und strobe count", nstb, 1);
        chk("und count", nund, 3);
    endtask

    // Reset 37 cycles into a symbol with one bit buffered.
    task automatic run_mid_reset();
        int ev = 0;
        do_reset();
        // Edges 0,1 accept 1,1; edge 2 loads; edge 3 buffers a single 0.
        for (int c = 0; c < 4; c++) begin
            Din_valid = (c != 2);
            Din       = (c < 2);
            cyc();
            if (c == 2) chk("rst first strobe", Sym_strobe, 1);
        end
        Din_valid = 1'b0;
        for (int c = 4; c < 39; c++) cyc();
        Rst = 1'b1;
        #1 chk("rst ready during reset", Din_ready, 0);
        cyc();
        chk("rst outputs cleared", {O, E, Sym_strobe, Underrun}, 4'b0000);
        Rst  = 1'b0;
        ph_m = 2'd0;
        // Idle must not run the symbol counter.
        for (int c = 0; c < 150; c++) begin
            cyc();
            if (Sym_strobe || Underrun) ev++;
        end
        chk("rst idle silent", ev, 0);
        Din_valid = 1'b1; Din = 1'b0; cyc();
        Din = 1'b1; cyc();
        Din_valid = 1'b0;
        cyc();
        chk("rst reload strobe", Sym_strobe, 1);
        chk("rst reload pair", {O, E}, enc(2'b00, 2'b01));
    endtask

    // Second bit of a dibit accepted on the boundary edge itself.
    task automatic run_boundary_accept();
        logic [1:0] p1;
        do_reset();
        Din_valid = 1'b1; Din = 1'b1; cyc();
        Din = 1'b0; cyc();
        Din_valid = 1'b0;
        cyc();
        chk("bnd first strobe", Sym_strobe, 1);
        p1 = enc(2'b00, 2'b10);
        for (int n = 1; n <= 200; n++) begin
            Din_valid = (n == 1) || (n == 100);
            Din       = 1'b1;
            cyc();
            if (n == 100) begin
                chk("bnd underrun on edge", Underrun, 1);
                chk("bnd no strobe on edge", Sym_strobe, 0);
                chk("bnd pair held", {O, E}, p1);
            end
            if (n == 101) begin
                #1 chk("bnd ready low after", Din_ready, 0);
            end
            if (n == 200) begin
                chk("bnd load next boundary", Sym_strobe, 1);
                chk("bnd no underrun", Underrun, 0);
                chk("bnd pair", {O, E}, enc(p1, 2'b11));
            end
        end
    endtask

    initial begin
        vec_t tbl[8];
        Rst = 1'b1; Din_valid = 1'b0; Din = 1'b0;
        //          rst   vld   din   rdy   o     e     stb   und
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        #2;
        for (int i = 0; i < 8; i++) begin
            Rst = tbl[i].rst; Din_valid = tbl[i].vld; Din = tbl[i].din;
            #1 chk($sformatf("vec%0d ready", i), Din_ready, tbl[i].rdy);
            cyc();
            chk($sformatf("vec%0d outputs", i), {O, E, Sym_strobe, Underrun},
                {tbl[i].o, tbl[i].e, tbl[i].stb, tbl[i].und});
        end

        run_stream("s110100", 8'b0000_1011, 6);
        run_stream("s4dibit", 8'b1101_1010, 8);
        run_underrun();
        run_mid_reset();
        run_boundary_accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
